// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, reads a word-addressed instruction memory and presents
// one registered instruction per cycle with stall, redirect and a program-load port.
module instr_fetch_unit #(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        prog_we_i,
  input  logic [31:0] prog_addr_i,
  input  logic [31:0] prog_data_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        instr_valid_o,
  output logic        misalign_o
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);

  logic [31:0]   imem [IMEM_DEPTH];
  logic [31:0]   f_pc;
  logic [AW-1:0] fetch_idx;
  logic [AW-1:0] prog_idx;
  logic          unused_prog_bits;

  assign fetch_idx        = f_pc[AW+1:2];
  assign prog_idx         = prog_addr_i[AW+1:2];
  assign unused_prog_bits = ^{prog_addr_i[31:AW+2], prog_addr_i[1:0]};

  // Memory is not reset; a same-edge write is seen by the fetch only on a later read.
  always_ff @(posedge clk) begin
    if (prog_we_i) begin
      imem[prog_idx] <= prog_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_pc          <= RESET_PC;
      instr_o       <= NOP_INSTR;
      pc_o          <= RESET_PC;
      instr_valid_o <= 1'b0;
      misalign_o    <= 1'b0;
    end else if (redirect_i) begin
      f_pc          <= {redirect_pc_i[31:2], 2'b00};
      instr_o       <= NOP_INSTR;
      instr_valid_o <= 1'b0;
      misalign_o    <= misalign_o | (redirect_pc_i[1:0] != 2'b00);
    end else if (!stall_i) begin
      instr_o       <= imem[fetch_idx];
      pc_o          <= f_pc;
      instr_valid_o <= 1'b1;
      f_pc          <= f_pc + 32'd4;
    end
  end

endmodule
